// File: rtl/simmem_wresp_delay_slots.sv
// simmem_wresp_delay_slots
//
// Write-response delay engine for the simulated memory controller. Every
// accepted write address claims one of NumSlots slots and starts a countdown
// loaded from cfg_delay_i. The matching B response from the real controller is
// parked in that slot. It is released to the requester once three conditions
// hold: the countdown is zero, the response has arrived, and every older slot
// with the same ID has already left. Different IDs may complete out of order.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cfg_delay_i                    countdown for the AW accepted this cycle
//   waddr_in_valid_i/ready_o       requester AW handshake (id in waddr_in_id_i)
//   waddr_out_valid_o/ready_i      AW handshake towards the real controller
//   wresp_in_valid_i/ready_o       B from the real controller (id, data)
//   wresp_out_valid_o/ready_i      B towards the requester (id, data)
//   occupancy_o                    number of valid slots (output reg excluded)
module simmem_wresp_delay_slots #(
  parameter int IdWidth    = 4,
  parameter int RespWidth  = 2,
  parameter int NumSlots   = 8,
  parameter int DelayWidth = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DelayWidth-1:0]          cfg_delay_i,
  input  logic                           waddr_in_valid_i,
  output logic                           waddr_in_ready_o,
  input  logic [IdWidth-1:0]             waddr_in_id_i,
  output logic                           waddr_out_valid_o,
  input  logic                           waddr_out_ready_i,
  input  logic                           wresp_in_valid_i,
  output logic                           wresp_in_ready_o,
  input  logic [IdWidth-1:0]             wresp_in_id_i,
  input  logic [RespWidth-1:0]           wresp_in_data_i,
  output logic                           wresp_out_valid_o,
  input  logic                           wresp_out_ready_i,
  output logic [IdWidth-1:0]             wresp_out_id_o,
  output logic [RespWidth-1:0]           wresp_out_data_o,
  output logic [$clog2(NumSlots+1)-1:0]  occupancy_o
);

  localparam int OccWidth = $clog2(NumSlots + 1);

  logic [NumSlots-1:0]   valid_q;
  logic [NumSlots-1:0]   has_resp_q;
  logic [IdWidth-1:0]    id_q    [NumSlots];
  logic [RespWidth-1:0]  data_q  [NumSlots];
  logic [DelayWidth-1:0] cnt_q   [NumSlots];
  // older_q[i][j] set: slot j was allocated before slot i
  logic [NumSlots-1:0]   older_q [NumSlots];

  logic                  ovalid_q;
  logic [IdWidth-1:0]    oid_q;
  logic [RespWidth-1:0]  odata_q;

  logic                  full;
  logic                  aw_hs;
  logic                  in_hs;
  logic                  load;
  logic [NumSlots-1:0]   alloc_oh;
  logic [NumSlots-1:0]   cand;
  logic [NumSlots-1:0]   ingest_oh;
  logic [NumSlots-1:0]   blocked;
  logic [NumSlots-1:0]   elig;
  logic [NumSlots-1:0]   rel_oh;
  logic [NumSlots-1:0]   release_mask;
  logic [IdWidth-1:0]    sel_id;
  logic [RespWidth-1:0]  sel_data;
  logic [OccWidth-1:0]   occ;

  // AW channel
  assign full              = &valid_q;
  assign waddr_out_valid_o = waddr_in_valid_i & ~full & ~rst_i;
  assign waddr_in_ready_o  = waddr_out_ready_i & ~full & ~rst_i;
  assign aw_hs             = waddr_in_valid_i & waddr_in_ready_o;

  // The lowest clear bit of valid_q: adding one ripples through the
  // trailing ones, and masking with ~valid_q keeps only that first zero.
  assign alloc_oh = ~valid_q & (valid_q + NumSlots'(1));

  // Response ingest goes to the oldest pending slot with a matching ID.
  always_comb begin
    cand      = '0;
    ingest_oh = '0;
    for (int i = 0; i < NumSlots; i++) begin
      cand[i] = valid_q[i] & ~has_resp_q[i] & (id_q[i] == wresp_in_id_i);
    end
    for (int i = 0; i < NumSlots; i++) begin
      ingest_oh[i] = cand[i] & ~|(cand & older_q[i]);
    end
  end

  assign wresp_in_ready_o = (|cand) & ~rst_i;
  assign in_hs            = wresp_in_valid_i & wresp_in_ready_o;

  // A slot is blocked while any older live slot carries the same ID.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NumSlots; i++) begin
      for (int j = 0; j < NumSlots; j++) begin
        if (older_q[i][j] && valid_q[j] && (id_q[j] == id_q[i])) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    elig   = '0;
    rel_oh = '0;
    for (int i = 0; i < NumSlots; i++) begin
      elig[i] = valid_q[i] & has_resp_q[i] & (cnt_q[i] == '0) & ~blocked[i];
    end
    for (int i = 0; i < NumSlots; i++) begin
      rel_oh[i] = elig[i] & ~|(elig & older_q[i]);
    end
  end

  assign load         = (~ovalid_q | wresp_out_ready_i) & (|elig);
  assign release_mask = load ? rel_oh : '0;

  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NumSlots; i++) begin
      sel_id   = sel_id | ({IdWidth{rel_oh[i]}} & id_q[i]);
      sel_data = sel_data | ({RespWidth{rel_oh[i]}} & data_q[i]);
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < NumSlots; i++) begin
      occ = occ + OccWidth'(valid_q[i]);
    end
  end

  assign occupancy_o = occ;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      has_resp_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]    <= '0;
        data_q[i]  <= '0;
        cnt_q[i]   <= '0;
        older_q[i] <= '0;
      end
      ovalid_q <= 1'b0;
      oid_q    <= '0;
      odata_q  <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (aw_hs && alloc_oh[i]) begin
          valid_q[i]    <= 1'b1;
          has_resp_q[i] <= 1'b0;
          id_q[i]       <= waddr_in_id_i;
          cnt_q[i]      <= cfg_delay_i;
          // A slot leaving on this same edge must not count as older.
          older_q[i]    <= valid_q & ~release_mask;
        end else begin
          if (release_mask[i]) begin
            valid_q[i] <= 1'b0;
          end
          if (valid_q[i] && (cnt_q[i] != '0)) begin
            cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
          end
          if (in_hs && ingest_oh[i]) begin
            has_resp_q[i] <= 1'b1;
            data_q[i]     <= wresp_in_data_i;
          end
          // The new slot is younger than everyone; this also wipes stale
          // bits left over from the previous tenant of that slot.
          if (aw_hs) begin
            older_q[i] <= older_q[i] & ~alloc_oh;
          end
        end
      end
      if (load) begin
        ovalid_q <= 1'b1;
        oid_q    <= sel_id;
        odata_q  <= sel_data;
      end else if (wresp_out_ready_i) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign wresp_out_valid_o = ovalid_q;
  assign wresp_out_id_o    = oid_q;
  assign wresp_out_data_o  = odata_q;

endmodule

// File: tb/tb_simmem_wresp_delay_slots.sv
module tb_simmem_wresp_delay_slots;
  localparam int IdWidth    = 4;
  localparam int RespWidth  = 2;
  localparam int NumSlots   = 8;
  localparam int DelayWidth = 8;
  localparam int OccWidth   = $clog2(NumSlots + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [DelayWidth-1:0] cfg_delay;
  logic                  aw_valid, aw_ready, aw_out_valid, aw_out_ready;
  logic [IdWidth-1:0]    aw_id;
  logic                  b_in_valid, b_in_ready;
  logic [IdWidth-1:0]    b_in_id;
  logic [RespWidth-1:0]  b_in_data;
  logic                  b_out_valid, b_out_ready;
  logic [IdWidth-1:0]    b_out_id;
  logic [RespWidth-1:0]  b_out_data;
  logic [OccWidth-1:0]   occ;

  simmem_wresp_delay_slots #(
    .IdWidth(IdWidth), .RespWidth(RespWidth),
    .NumSlots(NumSlots), .DelayWidth(DelayWidth)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_delay_i(cfg_delay),
    .waddr_in_valid_i(aw_valid), .waddr_in_ready_o(aw_ready),
    .waddr_in_id_i(aw_id),
    .waddr_out_valid_o(aw_out_valid), .waddr_out_ready_i(aw_out_ready),
    .wresp_in_valid_i(b_in_valid), .wresp_in_ready_o(b_in_ready),
    .wresp_in_id_i(b_in_id), .wresp_in_data_i(b_in_data),
    .wresp_out_valid_o(b_out_valid), .wresp_out_ready_i(b_out_ready),
    .wresp_out_id_o(b_out_id), .wresp_out_data_o(b_out_data),
    .occupancy_o(occ)
  );

  // Reference model: outstanding transactions in age order (index 0 oldest).
  // t_exp is the first cycle in which the transaction's delay has elapsed.
  typedef struct {
    int id;
    int data;
    int t_exp;
    bit has_resp;
  } txn_t;

  txn_t mq[$];
  bit   m_ovalid;
  int   m_oid, m_odata;
  int   cyc;

  bit e_aw_ready, e_aw_out_valid, e_b_ready, e_load;
  int e_ing, e_rel;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic idle();
    rst          = 1'b0;
    aw_valid     = 1'b0;
    aw_id        = '0;
    cfg_delay    = '0;
    aw_out_ready = 1'b1;
    b_in_valid   = 1'b0;
    b_in_id      = '0;
    b_in_data    = '0;
    b_out_ready  = 1'b1;
  endtask

  // Expected combinational results for the current cycle from model state.
  task automatic predict();
    bit blk;
    #1;
    e_aw_out_valid = !rst && aw_valid && (mq.size() < NumSlots);
    e_aw_ready     = !rst && aw_out_ready && (mq.size() < NumSlots);
    e_ing = -1;
    for (int k = 0; k < mq.size(); k++) begin
      if (e_ing < 0 && mq[k].id == int'(b_in_id) && !mq[k].has_resp) e_ing = k;
    end
    e_b_ready = !rst && (e_ing >= 0);
    e_rel = -1;
    for (int k = 0; k < mq.size(); k++) begin
      if (e_rel < 0 && mq[k].has_resp && cyc >= mq[k].t_exp) begin
        blk = 1'b0;
        for (int j = 0; j < k; j++) if (mq[j].id == mq[k].id) blk = 1'b1;
        if (!blk) e_rel = k;
      end
    end
    e_load = (!m_ovalid || b_out_ready) && (e_rel >= 0);
  endtask

  // Apply this cycle's events to the model, then move to the next cycle.
  task automatic commit();
    txn_t t;
    if (rst) begin
      mq.delete();
      m_ovalid = 1'b0;
      m_oid    = 0;
      m_odata  = 0;
    end else begin
      if (b_in_valid && e_b_ready) begin
        t = mq[e_ing];
        t.has_resp = 1'b1;
        t.data = int'(b_in_data);
        mq[e_ing] = t;
      end
      if (e_load) begin
        m_ovalid = 1'b1;
        m_oid    = mq[e_rel].id;
        m_odata  = mq[e_rel].data;
        mq.delete(e_rel);
      end else if (b_out_ready) begin
        m_ovalid = 1'b0;
      end
      if (aw_valid && e_aw_ready) begin
        t.id = int'(aw_id);
        t.data = 0;
        t.t_exp = cyc + int'(cfg_delay) + 1;
        t.has_resp = 1'b0;
        mq.push_back(t);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Answer every outstanding transaction and let everything drain.
  task automatic flush();
    int idx;
    for (int n = 0; n < 400; n++) begin
      if (mq.size() == 0 && !m_ovalid) break;
      idle();
      idx = -1;
      for (int k = 0; k < mq.size(); k++) if (idx < 0 && !mq[k].has_resp) idx = k;
      if (idx >= 0) begin
        b_in_valid = 1'b1;
        b_in_id    = IdWidth'(mq[idx].id);
        b_in_data  = RespWidth'($urandom_range(0, 3));
      end
      predict();
      n_tests++;
      if (occ !== OccWidth'(mq.size())) begin
        n_fail++;
        $display("FAIL flush_occupancy got=%0d exp=%0d", occ, mq.size());
      end
      commit();
    end
    n_tests++;
    if (mq.size() != 0 || m_ovalid || b_out_valid !== 1'b0 || occ !== '0) begin
      n_fail++;
      $display("FAIL flush_drain got_valid=%0b got_occ=%0d exp_valid=0 exp_occ=0",
               b_out_valid, occ);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; aw_valid = 1'b1; b_in_valid = 1'b1;
    predict();
    commit();
    predict();
    n_tests += 5;
    if (aw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_aw_ready got=%0b exp=0", aw_ready); end
    if (aw_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_aw_out_valid got=%0b exp=0", aw_out_valid); end
    if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_in_ready got=%0b exp=0", b_in_ready); end
    if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_out_valid got=%0b exp=0", b_out_valid); end
    if (occ !== '0) begin n_fail++; $display("FAIL rst_occupancy got=%0d exp=0", occ); end
    commit();
    idle();
    predict();
    n_tests += 4;
    if (b_out_id !== '0 || b_out_data !== '0) begin
      n_fail++; $display("FAIL rst_payload got_id=%0d got_data=%0d exp=0", b_out_id, b_out_data);
    end
    if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid2 got=%0b exp=0", b_out_valid); end
    if (aw_ready !== 1'b1) begin n_fail++; $display("FAIL rst_aw_ready_after got=%0b exp=1", aw_ready); end
    if (occ !== '0) begin n_fail++; $display("FAIL rst_occ_after got=%0d exp=0", occ); end
    commit();
  endtask

  task automatic test_single();
    bit ev;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k == 0) begin aw_valid = 1'b1; aw_id = 4'd3; cfg_delay = 8'd5; end
      if (k == 1) begin b_in_valid = 1'b1; b_in_id = 4'd3; b_in_data = 2'd2; end
      predict();
      ev = (k == 7);
      n_tests += 2;
      if (b_out_valid !== ev) begin n_fail++; $display("FAIL single_valid k=%0d got=%0b exp=%0b", k, b_out_valid, ev); end
      if (ev && (b_out_id !== 4'd3 || b_out_data !== 2'd2)) begin
        n_fail++; $display("FAIL single_payload got_id=%0d got_data=%0d exp_id=3 exp_data=2", b_out_id, b_out_data);
      end
      if (occ !== OccWidth'((k >= 1 && k <= 6) ? 1 : 0)) begin
        n_fail++; $display("FAIL single_occupancy k=%0d got=%0d", k, occ);
      end
      commit();
    end
    flush();
  endtask

  task automatic test_same_id();
    for (int k = 0; k < 16; k++) begin
      idle();
      if (k == 0) begin aw_valid = 1'b1; aw_id = 4'd1; cfg_delay = 8'd10; end
      if (k == 1) begin aw_valid = 1'b1; aw_id = 4'd1; cfg_delay = 8'd1; end
      if (k == 2) begin b_in_valid = 1'b1; b_in_id = 4'd1; b_in_data = 2'd1; end
      if (k == 3) begin b_in_valid = 1'b1; b_in_id = 4'd1; b_in_data = 2'd3; end
      predict();
      n_tests++;
      if (b_out_valid !== (k == 12 || k == 13)) begin
        n_fail++; $display("FAIL sameid_valid k=%0d got=%0b", k, b_out_valid);
      end
      if (k == 12 && (b_out_id !== 4'd1 || b_out_data !== 2'd1)) begin
        n_fail++; $display("FAIL sameid_first got_id=%0d got_data=%0d exp_id=1 exp_data=1", b_out_id, b_out_data);
      end
      if (k == 13 && (b_out_id !== 4'd1 || b_out_data !== 2'd3)) begin
        n_fail++; $display("FAIL sameid_second got_id=%0d got_data=%0d exp_id=1 exp_data=3", b_out_id, b_out_data);
      end
      commit();
    end
    flush();
  endtask

  task automatic test_cross_id();
    for (int k = 0; k < 25; k++) begin
      idle();
      if (k == 0) begin aw_valid = 1'b1; aw_id = 4'd2; cfg_delay = 8'd20; end
      if (k == 1) begin aw_valid = 1'b1; aw_id = 4'd5; cfg_delay = 8'd2; end
      if (k == 2) begin b_in_valid = 1'b1; b_in_id = 4'd2; b_in_data = 2'd1; end
      if (k == 3) begin b_in_valid = 1'b1; b_in_id = 4'd5; b_in_data = 2'd2; end
      predict();
      n_tests++;
      if (b_out_valid !== (k == 5 || k == 22)) begin
        n_fail++; $display("FAIL cross_valid k=%0d got=%0b", k, b_out_valid);
      end
      if (k == 5 && (b_out_id !== 4'd5 || b_out_data !== 2'd2)) begin
        n_fail++; $display("FAIL cross_first got_id=%0d got_data=%0d exp_id=5 exp_data=2", b_out_id, b_out_data);
      end
      if (k == 22 && (b_out_id !== 4'd2 || b_out_data !== 2'd1)) begin
        n_fail++; $display("FAIL cross_second got_id=%0d got_data=%0d exp_id=2 exp_data=1", b_out_id, b_out_data);
      end
      commit();
    end
    flush();
  endtask

  task automatic test_full();
    for (int k = 0; k < 14; k++) begin
      idle();
      if (k < 8) begin aw_valid = 1'b1; aw_id = IdWidth'(k); end
      else if (k < 12) begin aw_valid = 1'b1; aw_id = 4'd8; end
      if (k == 8) begin b_in_valid = 1'b1; b_in_id = 4'd15; end
      if (k == 9) begin b_in_valid = 1'b1; b_in_id = 4'd0; b_in_data = 2'd1; end
      predict();
      n_tests++;
      if (aw_ready !== (k < 8 || k == 11)) begin
        n_fail++; $display("FAIL full_aw_ready k=%0d got=%0b", k, aw_ready);
      end
      if (k == 8) begin
        n_tests += 3;
        if (occ !== OccWidth'(8)) begin n_fail++; $display("FAIL full_occupancy got=%0d exp=8", occ); end
        if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_unknown_id got=%0b exp=0", b_in_ready); end
        if (aw_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_aw_out_valid got=%0b exp=0", aw_out_valid); end
      end
      if (k == 11 && occ !== OccWidth'(7)) begin
        n_tests++; n_fail++; $display("FAIL full_occ_drain got=%0d exp=7", occ);
      end
      if (k == 12 && occ !== OccWidth'(8)) begin
        n_tests++; n_fail++; $display("FAIL full_occ_refill got=%0d exp=8", occ);
      end
      commit();
    end
    flush();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 11; k++) begin
      idle();
      b_out_ready = (k >= 8);
      if (k == 0) begin aw_valid = 1'b1; aw_id = 4'd4; end
      if (k == 1) begin aw_valid = 1'b1; aw_id = 4'd6; b_in_valid = 1'b1; b_in_id = 4'd4; b_in_data = 2'd1; end
      if (k == 2) begin b_in_valid = 1'b1; b_in_id = 4'd6; b_in_data = 2'd2; end
      predict();
      n_tests++;
      if (b_out_valid !== (k >= 3 && k <= 9)) begin
        n_fail++; $display("FAIL bp_valid k=%0d got=%0b", k, b_out_valid);
      end
      if (k >= 3 && k <= 8 && (b_out_id !== 4'd4 || b_out_data !== 2'd1)) begin
        n_fail++; $display("FAIL bp_hold k=%0d got_id=%0d got_data=%0d exp_id=4 exp_data=1", k, b_out_id, b_out_data);
      end
      if (k == 9 && (b_out_id !== 4'd6 || b_out_data !== 2'd2)) begin
        n_fail++; $display("FAIL bp_second got_id=%0d got_data=%0d exp_id=6 exp_data=2", b_out_id, b_out_data);
      end
      commit();
    end
    flush();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 13; k++) begin
      idle();
      if (k < 4) begin aw_valid = 1'b1; aw_id = IdWidth'(k); cfg_delay = 8'd50; end
      if (k == 4) begin
        rst = 1'b1; aw_valid = 1'b1; aw_id = 4'd9;
        b_in_valid = 1'b1; b_in_id = 4'd0;
      end
      if (k == 5) begin aw_valid = 1'b1; aw_id = 4'd7; cfg_delay = 8'd3; end
      if (k == 6) begin b_in_valid = 1'b1; b_in_id = 4'd7; b_in_data = 2'd3; end
      predict();
      if (k == 4) begin
        n_tests += 2;
        if (aw_ready !== 1'b0 || aw_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin
          n_fail++; $display("FAIL midrst_ready got_aw=%0b got_awo=%0b got_b=%0b exp=0", aw_ready, aw_out_valid, b_in_ready);
        end
        if (occ !== OccWidth'(4)) begin n_fail++; $display("FAIL midrst_occ_before got=%0d exp=4", occ); end
      end
      if (k == 5) begin
        n_tests += 2;
        if (b_out_id !== '0 || b_out_data !== '0 || occ !== '0) begin
          n_fail++; $display("FAIL midrst_after got_id=%0d got_data=%0d got_occ=%0d exp=0", b_out_id, b_out_data, occ);
        end
        if (aw_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_aw_ready got=%0b exp=1", aw_ready); end
      end
      n_tests++;
      if (b_out_valid !== (k == 10)) begin
        n_fail++; $display("FAIL midrst_valid k=%0d got=%0b", k, b_out_valid);
      end
      if (k == 10 && (b_out_id !== 4'd7 || b_out_data !== 2'd3)) begin
        n_fail++; $display("FAIL midrst_payload got_id=%0d got_data=%0d exp_id=7 exp_data=3", b_out_id, b_out_data);
      end
      commit();
    end
    flush();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 399) == 0);
      aw_valid     = 1'($urandom_range(0, 1));
      aw_id        = IdWidth'($urandom_range(0, 3));
      cfg_delay    = ($urandom_range(0, 7) == 0) ? DelayWidth'($urandom_range(0, 30))
                                                 : DelayWidth'($urandom_range(0, 4));
      aw_out_ready = ($urandom_range(0, 4) != 0);
      b_in_valid   = ($urandom_range(0, 2) != 0);
      b_in_id      = IdWidth'($urandom_range(0, 3));
      b_in_data    = RespWidth'($urandom_range(0, 3));
      b_out_ready  = ($urandom_range(0, 3) != 0);
      predict();
      n_tests += 5;
      if (b_out_valid !== m_ovalid) begin
        n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", cyc, b_out_valid, m_ovalid);
      end
      if (m_ovalid && (b_out_id !== IdWidth'(m_oid) || b_out_data !== RespWidth'(m_odata))) begin
        n_fail++; $display("FAIL rand_payload cyc=%0d got_id=%0d got_data=%0d exp_id=%0d exp_data=%0d",
                           cyc, b_out_id, b_out_data, m_oid, m_odata);
      end
      if (occ !== OccWidth'(mq.size())) begin
        n_fail++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", cyc, occ, mq.size());
      end
      if (aw_ready !== e_aw_ready || aw_out_valid !== e_aw_out_valid) begin
        n_fail++; $display("FAIL rand_aw cyc=%0d got_ready=%0b got_valid=%0b exp_ready=%0b exp_valid=%0b",
                           cyc, aw_ready, aw_out_valid, e_aw_ready, e_aw_out_valid);
      end
      if (b_in_ready !== e_b_ready) begin
        n_fail++; $display("FAIL rand_b_in_ready cyc=%0d got=%0b exp=%0b", cyc, b_in_ready, e_b_ready);
      end
      commit();
    end
    flush();
  endtask

  initial begin
    cyc = 0;
    m_ovalid = 1'b0;
    m_oid = 0;
    m_odata = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_single();
    test_same_id();
    test_cross_id();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
